// File: rtl/ru_result_drain_if.sv
// Control, host read/write port and result-stream signals of ru_result_drain.
// master is the drain engine's view; slave is the surrounding system's view.
interface ru_result_drain_if #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned WL    = 32
);
  logic             start;
  logic [ADDRW-1:0] count;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] rraddress;
  logic [WL-1:0]    rdata;
  logic [WL-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             wrena;
  logic [ADDRW-1:0] wraddress;
  logic [WL-1:0]    wdata;

  modport master (
    input  start, count, rdata, m_ready,
    output busy, done, rraddress, m_data, m_valid, m_last, wrena, wraddress, wdata
  );

  modport slave (
    output start, count, rdata, m_ready,
    input  busy, done, rraddress, m_data, m_valid, m_last, wrena, wraddress, wdata
  );
endinterface

// File: rtl/ru_result_drain.sv
// Readback engine for the reduce unit's destination buffer: credit-limited reads, output FIFO.
// Define RU_DRAIN_CLEAR_EN to zero-clear each location in the cycle its word is captured.
module ru_result_drain #(
  parameter int unsigned ADDRW = 16,
  parameter int unsigned WL    = 32,
  parameter int unsigned RDLAT = 2
) (
  input logic               clk,
  input logic               rst,
  ru_result_drain_if.master bus
);

  localparam int unsigned FD   = RDLAT + 2;
  localparam int unsigned PtrW = $clog2(FD);
  localparam int unsigned CntW = $clog2(FD + 1);
  localparam logic [CntW:0]   FdCredits = (CntW + 1)'(FD);
  localparam logic [PtrW-1:0] PtrMax    = PtrW'(FD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e           state_q;
  logic [ADDRW-1:0] count_q;
  logic [ADDRW-1:0] issue_idx_q;
  logic [ADDRW-1:0] last_addr_q;
  logic [ADDRW-1:0] accept_q;
  logic             busy_q;
  logic             done_q;

  logic [RDLAT-1:0] pipe_vld_q;
  logic [ADDRW-1:0] pipe_idx_q [RDLAT];

  logic [WL-1:0]    fifo_data_q [FD];
  logic             fifo_last_q [FD];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  occ_q;
  logic [CntW-1:0]  inflight_q;

  logic             issue;
  logic             capture;
  logic             pop;
  logic             cap_last;
  logic [ADDRW-1:0] cap_idx;
  logic [CntW:0]    credit_used;

  // Buffered plus in-flight words may never exceed the FIFO depth.
  assign credit_used = {1'b0, occ_q} + {1'b0, inflight_q};
  assign issue       = (state_q == StRun) && (credit_used < FdCredits);
  assign capture     = pipe_vld_q[RDLAT-1];
  assign cap_idx     = pipe_idx_q[RDLAT-1];
  assign cap_last    = (cap_idx == count_q - ADDRW'(1));
  assign pop         = (occ_q != '0) && bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      issue_idx_q <= '0;
      last_addr_q <= '0;
      accept_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      for (int unsigned i = 0; i < RDLAT; i++) pipe_idx_q[i] <= '0;
      for (int unsigned i = 0; i < FD; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      inflight_q  <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_idx_q[0] <= issue_idx_q;
      for (int unsigned i = 1; i < RDLAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end

      if (issue) begin
        issue_idx_q <= issue_idx_q + ADDRW'(1);
        last_addr_q <= issue_idx_q;
      end

      case ({issue, capture})
        2'b10:   inflight_q <= inflight_q + CntW'(1);
        2'b01:   inflight_q <= inflight_q - CntW'(1);
        default: ;
      endcase

      if (capture) begin
        fifo_data_q[wr_ptr_q] <= bus.rdata;
        fifo_last_q[wr_ptr_q] <= cap_last;
        wr_ptr_q              <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrW'(1);
      end

      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrW'(1);
        accept_q <= accept_q + ADDRW'(1);
      end

      case ({capture, pop})
        2'b10:   occ_q <= occ_q + CntW'(1);
        2'b01:   occ_q <= occ_q - CntW'(1);
        default: ;
      endcase

      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            count_q     <= bus.count;
            issue_idx_q <= '0;
            accept_q    <= '0;
            if (bus.count == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (issue && (issue_idx_q == count_q - ADDRW'(1))) state_q <= StFlush;
        end
        StFlush: begin
          if ((occ_q == '0) && (accept_q == count_q)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rraddress = issue ? issue_idx_q : last_addr_q;
  assign bus.m_valid   = (occ_q != '0);
  // Stream outputs read as zero whenever the FIFO is empty.
  assign bus.m_data    = bus.m_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign bus.m_last    = bus.m_valid ? fifo_last_q[rd_ptr_q] : 1'b0;

`ifdef RU_DRAIN_CLEAR_EN
  assign bus.wrena     = capture;
  assign bus.wraddress = capture ? cap_idx : '0;
`else
  assign bus.wrena     = 1'b0;
  assign bus.wraddress = '0;
`endif
  assign bus.wdata     = '0;

endmodule
